// File: rtl/eq_arbiter_if.sv
// Bus between the requesters, the shared equality comparator and eq_arbiter.
// The slave side is the arbiter; the master side is the requester/comparator environment.
`default_nettype none

interface eq_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = 16
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   done;
  logic           result;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic [W-1:0]   cmp_x;
  logic [W-1:0]   cmp_y;
  logic           cmp_z;
  logic           clr_count;
  logic [CW-1:0]  match_count;

  modport slave (
    input  req_valid, req_x, req_y, cmp_z, clr_count,
    output done, result, grant_id, busy, cmp_x, cmp_y, match_count
  );

  modport master (
    output req_valid, req_x, req_y, cmp_z, clr_count,
    input  done, result, grant_id, busy, cmp_x, cmp_y, match_count
  );
endinterface

`default_nettype wire

// File: rtl/eq_arbiter.sv
// Round-robin arbiter/sequencer sharing one external equality comparator among N requesters.
// Revision: 1.0 - initial release
`default_nettype none

module eq_arbiter #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  eq_arbiter_if.slave     bus
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic [W-1:0]    r_op_x;
  logic [W-1:0]    r_op_y;
  logic [N-1:0]    r_done;
  logic            r_result;
  logic            r_busy;
  logic [CW-1:0]   r_count;

  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_idx;
  logic            w_found;

  // Search ascends from r_ptr with wrap; first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = GW'((int'(r_ptr) + k) % N);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_op_x   <= '0;
      r_op_y   <= '0;
      r_done   <= '0;
      r_result <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_x  <= bus.req_x[int'(w_win)*W +: W];
            r_op_y  <= bus.req_y[int'(w_win)*W +: W];
            r_grant <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_result <= bus.cmp_z;
          if (bus.cmp_z && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
          end
          r_done  <= N'(1) << r_grant;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ptr   <= (r_grant == GW'(N-1)) ? '0 : r_grant + 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // A clear in the same cycle as an increment takes precedence.
      if (bus.clr_count) begin
        r_count <= '0;
      end
    end
  end

  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.grant_id    = r_grant;
  assign bus.busy        = r_busy;
  assign bus.cmp_x       = r_op_x;
  assign bus.cmp_y       = r_op_y;
  assign bus.match_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_eq_arbiter.sv
// Bench for eq_arbiter: vector table plus multi-cycle sequences, checked through a result scoreboard.
`default_nettype none

module tb_eq_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic rst_n;

  eq_arbiter_if #(.N(N), .W(W), .CW(16)) bus  ();
  eq_arbiter_if #(.N(N), .W(W), .CW(2))  bus2 ();

  eq_arbiter #(.N(N), .W(W), .CW(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  eq_arbiter #(.N(N), .W(W), .CW(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Behavioural comparators; the narrow-counter instance mirrors every stimulus.
  assign bus.cmp_z      = (bus.cmp_x == bus.cmp_y);
  assign bus2.cmp_z     = (bus2.cmp_x == bus2.cmp_y);
  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_x     = bus.req_x;
  assign bus2.req_y     = bus.req_y;
  assign bus2.clr_count = bus.clr_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   mask;
    logic [N*W-1:0] x;
    logic [N*W-1:0] y;
    int             g;
    logic           r;
  } vec_t;

  typedef struct {
    int          g;
    logic        r;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic r, input logic clr);
    exp_t e;
    if (clr) begin
      m_cnt  = '0;
      m_cnt2 = '0;
    end else if (r) begin
      if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 16'd1;
      if (m_cnt2 != 2'b11)    m_cnt2 = m_cnt2 + 2'd1;
    end
    e.g = g; e.r = r; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sbq.push_back(e);
  endtask

  // Returns the number of negedges until done was seen; lim+1 on timeout.
  task automatic wait_done(input int lim, output int k);
    k = 1;
    while (k <= lim) begin
      @(negedge clk);
      if (bus.done != '0) break;
      k++;
    end
    if (k > lim) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles at %0t", lim, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_onehot", 64'(bus.done), 64'(1) << e.g);
        chk("grant_id",    64'(bus.grant_id), 64'(e.g));
        chk("result",      64'(bus.result), 64'(e.r));
        chk("match_count", 64'(bus.match_count), 64'(e.cnt));
        chk("sat_count",   64'(bus2.match_count), 64'(e.cnt2));
        chk("sat_done",    64'(bus2.done), 64'(bus.done));
      end
    end
  end

  task automatic run_one(input vec_t v);
    int k;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = v.mask;
    bus.req_x     = v.x;
    bus.req_y     = v.y;
    push(v.g, v.r, 1'b0);
    @(negedge clk);
    chk("cmp_busy",  64'(bus.busy), 64'd1);
    chk("cmp_grant", 64'(bus.grant_id), 64'(v.g));
    chk("cmp_x",     64'(bus.cmp_x), 64'(v.x[v.g*W +: W]));
    chk("cmp_y",     64'(bus.cmp_y), 64'(v.y[v.g*W +: W]));
    wait_done(4, k);
    chk("latency", 64'(k), 64'd1);
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt = '0; m_cnt2 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[7];
  int   k;

  initial begin
    // ptr walk after reset: 0 ->1 ->3 ->1 ->0 ->2 ->1 ->2
    vecs[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 1'b1};
    vecs[1] = '{4'b0100, {32'h0, 32'hFFFFFFFF, 32'h0, 32'h0}, {32'h0, 32'hFF7FFFFF, 32'h0, 32'h0}, 2, 1'b0};
    vecs[2] = '{4'b0011, {32'h0, 32'h0, 32'h9, 32'h5}, {32'h0, 32'h0, 32'h8, 32'h5}, 0, 1'b1};
    vecs[3] = '{4'b1001, {32'hA5A5A5A5, 32'h0, 32'h0, 32'h1}, {32'hA5A5A5A4, 32'h0, 32'h0, 32'h1}, 3, 1'b0};
    vecs[4] = '{4'b1010, {32'h7, 32'h0, 32'hDEADBEEF, 32'h0}, {32'h7, 32'h0, 32'hDEADBEEF, 32'h0}, 1, 1'b1};
    vecs[5] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h80000000}, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 1'b0};
    vecs[6] = '{4'b1111, {32'h1, 32'h2, 32'h1234, 32'h4}, {32'h0, 32'h0, 32'h1234, 32'h0}, 1, 1'b1};

    n_tests = 0; n_fail = 0;
    m_cnt = '0; m_cnt2 = '0;
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.clr_count = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done",   64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_grant",  64'(bus.grant_id), 64'd0);
    chk("rst_busy",   64'(bus.busy), 64'd0);
    chk("rst_cmp_x",  64'(bus.cmp_x), 64'd0);
    chk("rst_count",  64'(bus.match_count), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_one(vecs[i]);

    // Fairness: all four held continuously, restarting from ptr=0.
    do_reset();
    @(negedge clk);
    bus.req_x = {32'h3, 32'h2, 32'hA, 32'h1};
    bus.req_y = {32'h3, 32'h2, 32'hA, 32'h0};
    bus.req_valid = 4'b1111;
    push(0, 1'b0, 1'b0); push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0);
    push(3, 1'b1, 1'b0); push(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_done(8, k);
      if (i == 0) chk("fair_first_latency", 64'(k), 64'd2);
      else        chk("fair_gap", 64'(k), 64'd3);
    end
    bus.req_valid = '0;

    // Operand change during CMP must not disturb the captured pair (ptr=1).
    @(negedge clk);
    bus.req_x = {32'h0, 32'h0, 32'h55, 32'h0};
    bus.req_y = {32'h0, 32'h0, 32'h55, 32'h0};
    bus.req_valid = 4'b0010;
    push(1, 1'b1, 1'b0);
    @(negedge clk);
    bus.req_x[63:32] = 32'h66;
    wait_done(4, k);
    chk("stable_cmp_x", 64'(bus.cmp_x), 64'h55);
    bus.req_valid = '0;

    // Clear coinciding with a match: count ends at zero.
    @(negedge clk);
    bus.req_x = {32'h0, 32'h7, 32'h0, 32'h0};
    bus.req_y = {32'h0, 32'h7, 32'h0, 32'h0};
    bus.req_valid = 4'b0100;
    push(2, 1'b1, 1'b1);
    @(negedge clk);
    bus.clr_count = 1'b1;
    wait_done(4, k);
    bus.clr_count = 1'b0;
    bus.req_valid = '0;

    // Reset during CMP (ptr=3 before), then pending request served from ptr=0.
    @(negedge clk);
    bus.req_x = {32'h9, 32'h0, 32'h9, 32'h0};
    bus.req_y = {32'h9, 32'h0, 32'h9, 32'h0};
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("prerst_grant", 64'(bus.grant_id), 64'd3);
    rst_n = 1'b0;
    m_cnt = '0; m_cnt2 = '0;
    #1;
    chk("mid_rst_done",   64'(bus.done), 64'd0);
    chk("mid_rst_result", 64'(bus.result), 64'd0);
    chk("mid_rst_grant",  64'(bus.grant_id), 64'd0);
    chk("mid_rst_busy",   64'(bus.busy), 64'd0);
    chk("mid_rst_cmp",    64'({bus.cmp_x, bus.cmp_y}), 64'd0);
    chk("mid_rst_count",  64'(bus.match_count), 64'd0);
    @(negedge clk);
    chk("rst_no_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    push(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.grant_id), 64'd1);
    wait_done(4, k);
    chk("post_rst_latency", 64'(k), 64'd1);
    bus.req_valid = '0;

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
